// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped down-counting timer:
// register offsets, CTRL field positions, mode encodings and FSM states.
package timer_pkg;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

endpackage

// File: rtl/timer_dev.sv
// Bus-attached down-counting timer with CTRL/PRESET/COUNT registers,
// one-shot or auto-reload modes, and a maskable interrupt request.
module timer_dev
  import timer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       a,
  input  logic             we,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] rd,
  output logic             irq
);

  state_e           state_q, state_d;
  logic             en_q, en_d;
  logic             im_q, im_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] preset_q, preset_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             flag_q, flag_d;

  // CTRL bits above IM are not stored
  logic unused_wd_hi;
  assign unused_wd_hi = ^wd[WIDTH-1:4];

  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    im_d     = im_q;
    mode_d   = mode_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;

    case (state_q)
      ST_IDLE: if (en_q) state_d = ST_LOAD;
      ST_LOAD: begin
        if (!en_q) state_d = ST_IDLE;
        else begin
          count_d = preset_q;
          state_d = ST_CNT;
        end
      end
      ST_CNT: begin
        if (!en_q) state_d = ST_IDLE;
        else if (count_q != '0) count_d = count_q - WIDTH'(1);
        else begin
          state_d = ST_INT;
          flag_d  = 1'b1;
        end
      end
      ST_INT: begin
        // MODE 1x behaves as one-shot
        if (mode_q == MODE_RELOAD) begin
          state_d = ST_LOAD;
          flag_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
          en_d    = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // CPU write overrides the FSM's update of the same register
    if (we) begin
      case (a)
        OFF_CTRL: begin
          en_d   = wd[CTRL_EN];
          mode_d = wd[CTRL_MODE_HI:CTRL_MODE_LO];
          im_d   = wd[CTRL_IM];
          flag_d = 1'b0;
        end
        OFF_PRESET: begin
          preset_d = wd;
          flag_d   = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      en_q     <= 1'b0;
      im_q     <= 1'b0;
      mode_q   <= MODE_ONESHOT;
      preset_q <= '0;
      count_q  <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      im_q     <= im_d;
      mode_q   <= mode_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

  always_comb begin
    rd = '0;
    case (a)
      OFF_CTRL: begin
        rd[CTRL_EN]                   = en_q;
        rd[CTRL_MODE_HI:CTRL_MODE_LO] = mode_q;
        rd[CTRL_IM]                   = im_q;
      end
      OFF_PRESET: rd = preset_q;
      OFF_COUNT:  rd = count_q;
      OFF_RSVD:   rd = '0;
      default:    rd = '0;
    endcase
  end

  assign irq = flag_q & im_q;

endmodule

// File: doc/timer_dev.md
# timer_dev

Memory-mapped down-counting timer sitting directly behind the system bus bridge, in one of its two device windows. It exposes three word registers (CTRL, PRESET, COUNT) addressed by a 2-bit word offset supplied by the bridge. It drives one interrupt request line into the bridge's interrupt vector. COUNT is read-only; writes to it are rejected upstream and also ignored here.

## Interface
Parameters:
- WIDTH, 32, width of PRESET/COUNT and of the data bus.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- a  in  2  word offset within the window (bridge address minus window base, bits [3:2]).
- we  in  1  write strobe, already qualified by window hit and error checks.
- wd  in  WIDTH  write data.
- rd  out  WIDTH  read data, combinational from a.
- irq  out  1  interrupt request to bridge.

## Operation
- Register map: offset 0 CTRL, 1 PRESET, 2 COUNT (RO), 3 reserved (reads 0, writes ignored).
- CTRL bits: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00), [3] IM (interrupt mask, 1 = enabled). Bits [WIDTH-1:4] read 0, not stored.
- Reset: CTRL=0, PRESET=0, COUNT=0, state IDLE, flag=0, irq=0, rd reflects offset 0 (0).
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: EN=1 → LOAD; else stay.
  - LOAD: COUNT<=PRESET; → CNT (EN=0 → IDLE instead, no load).
  - CNT: EN=0 → IDLE, COUNT frozen; COUNT≠0 → COUNT<=COUNT-1, stay; COUNT=0 → INT, flag<=1.
  - INT: MODE 00 → IDLE, CTRL.EN<=0, flag held; MODE 01 → LOAD, flag<=0.
- irq = flag & IM. One-shot flag persists until any write to CTRL or PRESET clears it; auto-reload flag is a 1-cycle pulse.
- CPU write vs FSM update same edge: CPU write wins for the written register (e.g. CTRL write in INT with MODE 00 keeps written EN). Write also clears flag.
- PRESET write mid-count does not affect COUNT until next LOAD.
- CTRL write with EN=0 during CNT: FSM to IDLE next edge, COUNT retains value.
- Arithmetic: unsigned, WIDTH bits; COUNT never decrements below 0 (no wrap). PRESET=0 is legal: INT one cycle after LOAD.

## Timing
- Read: zero latency, rd valid in the same cycle as a.
- Write: takes effect at the edge where we=1; readback visible next cycle.
- From CTRL write edge E0 (EN=1, PRESET=P): E1 LOAD, E2 COUNT=P, E(2+P) COUNT=0, E(3+P) state INT and irq=1 (if IM). irq rises P+3 cycles after E0.
- Auto-reload period: P+3 cycles (LOAD, P+1 CNT cycles, INT); irq high exactly 1 cycle per period.
- rst_n assertion at any point forces all reset values immediately, irq drops asynchronously.

## Structure
- Shared package timer_pkg: register offsets (OFF_CTRL=0, OFF_PRESET=1, OFF_COUNT=2), CTRL bit positions, MODE encodings, FSM state enum (2 bits).
- Single module; no sub-module needed. FSM next-state and register-write priority in one sequential process; read mux combinational.

## Test plan
- Reset: assert rst_n=0 mid-count with irq high → all reads 0, irq=0 immediately; after release, IDLE.
- One-shot: PRESET=5, CTRL=0b1001 → irq rises 8 cycles after CTRL write, stays high; CTRL reads 0b1000; COUNT reads 0; write CTRL=0 clears irq.
- Auto-reload: PRESET=2, CTRL=0b1011 → irq 1-cycle pulses every 5 cycles; COUNT sequence 2,1,0 repeating.
- Mask/pause: IM=0 one-shot PRESET=3 → flag sets, irq stays 0; in another run write EN=0 at COUNT=2 → COUNT frozen at 2, no irq; EN=1 reloads to PRESET.
- PRESET=0 one-shot → irq 3 cycles after CTRL write; write to offset 2 (0xdead) and offset 3 ignored, read 0 from offset 3.
- Collision: CTRL write (EN=1, MODE 00) on the same edge FSM is in INT → CTRL.EN stays 1, flag cleared, FSM to IDLE then LOAD.
